video_out_mixer: RTL and testbench

Final pixel stage of the Denise re-implementation, directly downstream of the colour look-up table. It captures per-pixel control alongside each CLUT read and delays it to line up with the CLUT's 2-cycle read latency. It then applies Hold-And-Modify (HAM), Extra-Half-Brite (EHB) and blanking, and registers the final 12-bit RGB with a valid strobe for the video DAC/encoder.

---
 rtl/video_out_mixer.sv | 97 +++++++++
 tb/tb_video_out_mixer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/video_out_mixer.sv
// Final pixel stage: delays per-pixel control to match the 2-cycle CLUT read, then applies
// blanking, sprite bypass, HAM and EHB, and registers the 12-bit RGB with a valid strobe.
module video_out_mixer #(
    parameter bit HAM_ENABLE = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_rd,
    input  logic [5:0]  pix_bits,
    input  logic        spr_sel,
    input  logic        ham_en,
    input  logic        ehb_en,
    input  logic        blank,
    input  logic [11:0] clut_rgb,
    output logic [11:0] rgb_out,
    output logic        rgb_vld
);

    typedef struct packed {
        logic [5:0] bits;
        logic       spr;
        logic       ham;
        logic       ehb;
        logic       blank;
    } ctl_t;

    ctl_t        ctl0_q, ctl0_d;
    ctl_t        ctl1_q;
    logic        vld0_q, vld1_q;
    logic [11:0] hold_q, hold_d;
    logic [11:0] rgb_q, rgb_d;
    logic        vld_q;
    logic        ham_act;

    always_comb begin
        ctl0_d = ctl0_q;
        if (pix_rd) begin
            ctl0_d = '{bits: pix_bits, spr: spr_sel, ham: ham_en, ehb: ehb_en, blank: blank};
        end
    end

    assign ham_act = HAM_ENABLE && ctl1_q.ham;

    // Priority: blank > sprite > HAM > EHB > plain CLUT colour.
    always_comb begin
        rgb_d  = clut_rgb;
        hold_d = hold_q;
        if (ctl1_q.blank) begin
            rgb_d  = 12'h000;
            hold_d = clut_rgb;
        end else if (ctl1_q.spr) begin
            rgb_d = clut_rgb;
        end else if (ham_act) begin
            unique case (ctl1_q.bits[5:4])
                2'b00: rgb_d = clut_rgb;
                2'b01: rgb_d = {hold_q[11:4], ctl1_q.bits[3:0]};
                2'b10: rgb_d = {ctl1_q.bits[3:0], hold_q[7:0]};
                2'b11: rgb_d = {hold_q[11:8], ctl1_q.bits[3:0], hold_q[3:0]};
                default: rgb_d = clut_rgb;
            endcase
            hold_d = rgb_d;
        end else if (ctl1_q.ehb && ctl1_q.bits[5]) begin
            rgb_d  = {1'b0, clut_rgb[11:9], 1'b0, clut_rgb[7:5], 1'b0, clut_rgb[3:1]};
            hold_d = rgb_d;
        end else begin
            hold_d = rgb_d;
        end
        if (!vld1_q) begin
            rgb_d  = rgb_q;
            hold_d = hold_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctl0_q <= '0;
            ctl1_q <= '0;
            vld0_q <= 1'b0;
            vld1_q <= 1'b0;
            hold_q <= 12'h000;
            rgb_q  <= 12'h000;
            vld_q  <= 1'b0;
        end else begin
            ctl0_q <= ctl0_d;
            ctl1_q <= ctl0_q;
            vld0_q <= pix_rd;
            vld1_q <= vld0_q;
            hold_q <= hold_d;
            rgb_q  <= rgb_d;
            vld_q  <= vld1_q;
        end
    end

    assign rgb_out = rgb_q;
    assign rgb_vld = vld_q;

endmodule

// File: tb/tb_video_out_mixer.sv
// Directed bench for video_out_mixer; a two-stage CLUT stand-in feeds clut_rgb in step with pix_rd.
module tb_video_out_mixer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pix_rd;
    logic [5:0]  pix_bits;
    logic        spr_sel, ham_en, ehb_en, blank;
    logic [11:0] clut_rgb;
    logic [11:0] rgb_out;
    logic        rgb_vld;

    logic [11:0] col_req, c0, c1;
    int          checks = 0;
    int          errors = 0;
    logic [11:0] got_q[$];
    bit          vld_hist[$];

    always #5 clk = ~clk;

    // Colour table stand-in: colour requested with pix_rd appears two cycles later.
    always @(posedge clk) begin
        c0 <= col_req;
        c1 <= c0;
    end
    assign clut_rgb = c1;

    always @(negedge clk) begin
        vld_hist.push_back(rgb_vld);
        if (rgb_vld) got_q.push_back(rgb_out);
    end

    video_out_mixer #(.HAM_ENABLE(1'b1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pix_rd   (pix_rd),
        .pix_bits (pix_bits),
        .spr_sel  (spr_sel),
        .ham_en   (ham_en),
        .ehb_en   (ehb_en),
        .blank    (blank),
        .clut_rgb (clut_rgb),
        .rgb_out  (rgb_out),
        .rgb_vld  (rgb_vld)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        got_q.delete();
        vld_hist.delete();
    endtask

    // One pixel read; control is scrambled afterwards since it must be ignored without pix_rd.
    task automatic pix(input logic [5:0] b, input logic s, input logic h, input logic e,
                       input logic k, input logic [11:0] c);
        pix_rd = 1'b1; pix_bits = b; spr_sel = s; ham_en = h; ehb_en = e; blank = k;
        col_req = c;
        tick();
        pix_rd = 1'b0; pix_bits = 6'h2A; spr_sel = ~s; ham_en = ~h; ehb_en = ~e; blank = ~k;
        col_req = 12'hEEE;
    endtask

    task automatic idle(input int n);
        pix_rd = 1'b0;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pix_rd = 1'b0; pix_bits = '0; spr_sel = 0; ham_en = 0; ehb_en = 0;
        blank = 0; col_req = 12'h000;
        repeat (3) tick();
        checks++;
        if (rgb_out !== 12'h000) begin
            errors++; $display("FAIL reset_rgb got %h exp 000", rgb_out);
        end
        checks++;
        if (rgb_vld !== 1'b0) begin
            errors++; $display("FAIL reset_vld got %b exp 0", rgb_vld);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_passthrough();
        clr();
        pix(6'h05, 0, 0, 0, 0, 12'hABC);
        idle(6);
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (vld_hist.size() <= i || vld_hist[i] !== (i == 3)) begin
                errors++; $display("FAIL pass_vld[%0d] got %b exp %b", i,
                                   (vld_hist.size() > i) ? vld_hist[i] : 1'bx, i == 3);
            end
        end
        checks++;
        if (got_q.size() != 1 || got_q[0] !== 12'hABC) begin
            errors++; $display("FAIL pass_rgb got %0d items exp 1 of abc", got_q.size());
        end
        checks++;
        if (rgb_out !== 12'hABC || rgb_vld !== 1'b0) begin
            errors++; $display("FAIL pass_hold got %h/%b exp abc/0", rgb_out, rgb_vld);
        end
    endtask

    task automatic test_ham();
        logic [11:0] exp_q[4] = '{12'h000, 12'h12F, 12'h52F, 12'h5AF};
        clr();
        pix(6'h00, 0, 1, 0, 1, 12'h123);
        pix(6'h1F, 0, 1, 0, 0, 12'h777);
        pix(6'h25, 0, 1, 0, 0, 12'h777);
        pix(6'h3A, 0, 1, 0, 0, 12'h777);
        idle(5);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_q.size() <= i || got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL ham[%0d] got %h exp %h", i,
                                   (got_q.size() > i) ? got_q[i] : 12'hxxx, exp_q[i]);
            end
        end
    endtask

    task automatic test_ehb();
        logic [11:0] exp_q[3] = '{12'h747, 12'hF8E, 12'h18E};
        clr();
        pix(6'h21, 0, 0, 1, 0, 12'hF8E);
        pix(6'h01, 0, 0, 1, 0, 12'hF8E);
        pix(6'h21, 0, 1, 1, 0, 12'h000);
        idle(5);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got_q.size() <= i || got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL ehb[%0d] got %h exp %h", i,
                                   (got_q.size() > i) ? got_q[i] : 12'hxxx, exp_q[i]);
            end
        end
    endtask

    task automatic test_sprite();
        logic [11:0] exp_q[3] = '{12'h456, 12'hF00, 12'h450};
        clr();
        pix(6'h00, 0, 0, 0, 0, 12'h456);
        pix(6'h00, 1, 1, 0, 0, 12'hF00);
        pix(6'h10, 0, 1, 0, 0, 12'h999);
        idle(5);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got_q.size() <= i || got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL sprite[%0d] got %h exp %h", i,
                                   (got_q.size() > i) ? got_q[i] : 12'hxxx, exp_q[i]);
            end
        end
    endtask

    task automatic test_gapped();
        bit          exp_v[10] = '{0, 0, 0, 1, 0, 1, 1, 0, 0, 0};
        logic [11:0] exp_q[3]  = '{12'h111, 12'h222, 12'h333};
        clr();
        pix(6'h00, 0, 0, 0, 0, 12'h111);
        idle(1);
        pix(6'h00, 0, 0, 0, 0, 12'h222);
        pix(6'h00, 0, 0, 0, 0, 12'h333);
        idle(7);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (vld_hist.size() <= i || vld_hist[i] !== exp_v[i]) begin
                errors++; $display("FAIL gap_vld[%0d] got %b exp %b", i,
                                   (vld_hist.size() > i) ? vld_hist[i] : 1'bx, exp_v[i]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got_q.size() <= i || got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL gap_rgb[%0d] got %h exp %h", i,
                                   (got_q.size() > i) ? got_q[i] : 12'hxxx, exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_midstream();
        pix(6'h00, 0, 0, 0, 0, 12'hAAA);
        pix(6'h00, 0, 0, 0, 0, 12'hBBB);
        pix(6'h00, 0, 0, 0, 0, 12'hCCC);
        checks++;
        if (rgb_out !== 12'hAAA || rgb_vld !== 1'b1) begin
            errors++; $display("FAIL mid_pre got %h/%b exp aaa/1", rgb_out, rgb_vld);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rgb_out !== 12'h000 || rgb_vld !== 1'b0) begin
            errors++; $display("FAIL mid_async got %h/%b exp 000/0", rgb_out, rgb_vld);
        end
        idle(3);
        rst_n = 1'b1;
        clr();
        idle(6);
        checks++;
        if (got_q.size() != 0) begin
            errors++; $display("FAIL mid_stale got %0d strobes exp 0", got_q.size());
        end
        clr();
        pix(6'h1F, 0, 1, 0, 0, 12'hABC);
        idle(5);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== 12'h00F) begin
            errors++; $display("FAIL mid_ham got %h (%0d items) exp 00f",
                               (got_q.size() > 0) ? got_q[0] : 12'hxxx, got_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_ham();
        test_ehb();
        test_sprite();
        test_gapped();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
